pc_sequencer: RTL and testbench

Controller that sequences the 23-bit PIC24 program counter. It arbitrates three requesters (interrupt vector, branch/call target, sequential increment) and converts the winning request into the counter's pulse/bus protocol. The protocol is a pcinc pulse, or a pcload pulse followed by the LSW and then the MSW on the 16-bit databus. It sits between decode/interrupt logic and program_counter, and acknowledges each requester once the counter update is complete.

---
 rtl/pc_pkg.sv | 42 ++++
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_req_arbiter.sv | 41 ++++
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the PIC24 PC sequencer.
// Sequencer states, request sources and address helpers.
package pc_pkg;

  localparam int PC_ADDR_W = 24;
  localparam int PC_BUS_W  = 16;

  localparam logic [PC_ADDR_W-1:0] IVT_BASE_DEFAULT = 24'h000004;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INC_CMD  = 3'd1,
    S_INC_WAIT = 3'd2,
    S_LD_CMD   = 3'd3,
    S_LD_LSW   = 3'd4,
    S_LD_MSW   = 3'd5
  } pc_seq_state_e;

  typedef enum logic [1:0] {
    SRC_INC = 2'd0,
    SRC_BR  = 2'd1,
    SRC_IRQ = 2'd2
  } pc_src_e;

  // Program memory addresses are even and only 23 bits wide.
  function automatic logic [PC_ADDR_W-1:0] pc_sanitize(
    input logic [PC_ADDR_W-1:0] a
  );
    logic [PC_ADDR_W-1:0] r;
    r = a;
    r[0] = 1'b0;
    r[PC_ADDR_W-1] = 1'b0;
    return r;
  endfunction

  function automatic logic pc_addr_bad(
    input logic [PC_ADDR_W-1:0] a
  );
    return a[0] | a[PC_ADDR_W-1];
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/ack handshakes from decode and interrupt
// logic into the PC sequencer.
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int VEC_W = 8
);

  logic                 inc_req;
  logic                 br_req;
  logic                 irq_req;
  logic [PC_ADDR_W-1:0] br_addr;
  logic [VEC_W-1:0]     irq_vec;
  logic                 inc_ack;
  logic                 br_ack;
  logic                 irq_ack;

  modport master (
    output inc_req, br_req, irq_req,
    output br_addr, irq_vec,
    input  inc_ack, br_ack, irq_ack
  );

  modport slave (
    input  inc_req, br_req, irq_req,
    input  br_addr, irq_vec,
    output inc_ack, br_ack, irq_ack
  );

  modport arb (
    input inc_req, br_req, irq_req
  );

endinterface

// File: rtl/pc_req_arbiter.sv
// pc_req_arbiter: fixed-priority grant irq > br > inc.
// Produces a one-hot grant {irq, br, inc} and its source code.
module pc_req_arbiter
  import pc_pkg::*;
(
  pc_sequencer_if.arb req_if,
  output logic [2:0]  gnt_o,
  output pc_src_e     src_o
);

  logic [2:0] pri;

  assign pri[2] = req_if.irq_req;
  assign pri[1] = req_if.br_req & ~req_if.irq_req;
  assign pri[0] = req_if.inc_req & ~req_if.br_req
                & ~req_if.irq_req;

  always_comb begin
    gnt_o = 3'b000;
    src_o = SRC_INC;
    unique case (1'b1)
      pri[2]: begin
        gnt_o = 3'b100;
        src_o = SRC_IRQ;
      end
      pri[1]: begin
        gnt_o = 3'b010;
        src_o = SRC_BR;
      end
      pri[0]: begin
        gnt_o = 3'b001;
        src_o = SRC_INC;
      end
      default: begin
        gnt_o = 3'b000;
        src_o = SRC_INC;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: arbitrates PC update requests and drives the
// program_counter pcinc / pcload + LSW/MSW bus protocol.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [PC_ADDR_W-1:0] IVT_BASE = IVT_BASE_DEFAULT,
  parameter int                   VEC_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_req_i,
  output logic                 inc_ack_o,
  input  logic                 br_req_i,
  input  logic [PC_ADDR_W-1:0] br_addr_i,
  output logic                 br_ack_o,
  input  logic                 irq_req_i,
  input  logic [VEC_W-1:0]     irq_vec_i,
  output logic                 irq_ack_o,
  output logic                 pcinc_o,
  output logic                 pcload_o,
  output logic [PC_BUS_W-1:0]  pc_data_o,
  output logic                 pc_data_en_o,
  output logic                 busy_o,
  output logic                 addr_err_o
);

  pc_sequencer_if #(.VEC_W(VEC_W)) req_if ();

  assign req_if.inc_req = inc_req_i;
  assign req_if.br_req  = br_req_i;
  assign req_if.irq_req = irq_req_i;
  assign req_if.br_addr = br_addr_i;
  assign req_if.irq_vec = irq_vec_i;
  assign inc_ack_o      = req_if.inc_ack;
  assign br_ack_o       = req_if.br_ack;
  assign irq_ack_o      = req_if.irq_ack;

  logic [2:0] gnt;
  pc_src_e    gnt_src;

  pc_req_arbiter u_arb (
    .req_if (req_if),
    .gnt_o  (gnt),
    .src_o  (gnt_src)
  );

  pc_seq_state_e        state_q, state_d;
  logic [PC_ADDR_W-1:0] ld_addr_q, ld_addr_d;
  pc_src_e              src_q, src_d;
  logic                 err_q, err_d;

  logic [PC_ADDR_W-1:0] irq_addr;
  logic [PC_ADDR_W-1:0] raw_addr;

  // Vector entries are 2 bytes apart; carry out of bit 23 drops.
  assign irq_addr = IVT_BASE
                  + (PC_ADDR_W'(req_if.irq_vec) << 1);
  assign raw_addr = (gnt_src == SRC_IRQ) ? irq_addr
                                         : req_if.br_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ld_addr_q <= '0;
      src_q     <= SRC_INC;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      src_q     <= src_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    src_d     = src_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt[0]) begin
          state_d = S_INC_CMD;
        end else if (|gnt[2:1]) begin
          state_d   = S_LD_CMD;
          ld_addr_d = pc_sanitize(raw_addr);
          err_d     = pc_addr_bad(raw_addr);
          src_d     = gnt_src;
        end
      end
      S_INC_CMD:  state_d = S_INC_WAIT;
      S_INC_WAIT: state_d = S_IDLE;
      S_LD_CMD:   state_d = S_LD_LSW;
      S_LD_LSW:   state_d = S_LD_MSW;
      S_LD_MSW:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pcinc_o        = 1'b0;
    pcload_o       = 1'b0;
    pc_data_o      = '0;
    pc_data_en_o   = 1'b0;
    busy_o         = 1'b1;
    addr_err_o     = 1'b0;
    req_if.inc_ack = 1'b0;
    req_if.br_ack  = 1'b0;
    req_if.irq_ack = 1'b0;
    unique case (state_q)
      S_IDLE:     busy_o = 1'b0;
      S_INC_CMD:  pcinc_o = 1'b1;
      S_INC_WAIT: req_if.inc_ack = 1'b1;
      S_LD_CMD:   pcload_o = 1'b1;
      S_LD_LSW: begin
        pc_data_en_o = 1'b1;
        pc_data_o    = ld_addr_q[15:0];
      end
      S_LD_MSW: begin
        pc_data_en_o   = 1'b1;
        pc_data_o      = {8'h00, ld_addr_q[23:16]};
        addr_err_o     = err_q;
        req_if.br_ack  = (src_q == SRC_BR);
        req_if.irq_ack = (src_q == SRC_IRQ);
      end
      default:    busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer
// against a transaction-level reference and a program_counter model.
`timescale 1ns/1ps
module tb_pc_sequencer;
  import pc_pkg::*;

  typedef struct packed {
    logic        pcinc;
    logic        pcload;
    logic [15:0] data;
    logic        en;
    logic        busy;
    logic        irq_ack;
    logic        br_ack;
    logic        inc_ack;
    logic        err;
  } vec_t;

  localparam logic [23:0] IVT1 = 24'h000004;
  localparam logic [23:0] IVT2 = 24'hFFFFFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if #(.VEC_W(8)) rq ();
  pc_sequencer_if #(.VEC_W(8)) rq2 ();

  logic        pcinc, pcload, en, busy, err;
  logic [15:0] data;
  logic        pcinc2, pcload2, en2, busy2, err2;
  logic [15:0] data2;

  pc_sequencer #(.IVT_BASE(IVT1), .VEC_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .inc_req_i(rq.inc_req), .inc_ack_o(rq.inc_ack),
    .br_req_i(rq.br_req), .br_addr_i(rq.br_addr),
    .br_ack_o(rq.br_ack),
    .irq_req_i(rq.irq_req), .irq_vec_i(rq.irq_vec),
    .irq_ack_o(rq.irq_ack),
    .pcinc_o(pcinc), .pcload_o(pcload),
    .pc_data_o(data), .pc_data_en_o(en),
    .busy_o(busy), .addr_err_o(err)
  );

  pc_sequencer #(.IVT_BASE(IVT2), .VEC_W(8)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .inc_req_i(rq2.inc_req), .inc_ack_o(rq2.inc_ack),
    .br_req_i(rq2.br_req), .br_addr_i(rq2.br_addr),
    .br_ack_o(rq2.br_ack),
    .irq_req_i(rq2.irq_req), .irq_vec_i(rq2.irq_vec),
    .irq_ack_o(rq2.irq_ack),
    .pcinc_o(pcinc2), .pcload_o(pcload2),
    .pc_data_o(data2), .pc_data_en_o(en2),
    .busy_o(busy2), .addr_err_o(err2)
  );

  // Behavioural program_counter fed by the sequencer's pins.
  logic [23:0] pc_m;
  logic [15:0] lsw_m;
  logic        ph_m;
  always @(posedge clk) begin
    if (!rst_n) begin
      pc_m <= '0; lsw_m <= '0; ph_m <= 1'b0;
    end else if (pcinc) begin
      pc_m <= (pc_m + 24'd2) & 24'h7FFFFF;
    end else if (pcload) begin
      ph_m <= 1'b0;
    end else if (en) begin
      if (!ph_m) lsw_m <= data;
      else pc_m <= {data[7:0], lsw_m};
      ph_m <= ~ph_m;
    end
  end

  function automatic vec_t obs();
    vec_t v;
    v.pcinc = pcinc; v.pcload = pcload; v.data = data;
    v.en = en; v.busy = busy; v.irq_ack = rq.irq_ack;
    v.br_ack = rq.br_ack; v.inc_ack = rq.inc_ack; v.err = err;
    return v;
  endfunction

  function automatic vec_t obs2();
    vec_t v;
    v.pcinc = pcinc2; v.pcload = pcload2; v.data = data2;
    v.en = en2; v.busy = busy2; v.irq_ack = rq2.irq_ack;
    v.br_ack = rq2.br_ack; v.inc_ack = rq2.inc_ack; v.err = err2;
    return v;
  endfunction

  // ack bits ordered {irq, br, inc}
  function automatic vec_t mk(input logic pi, input logic pl,
                              input logic [15:0] d, input logic de,
                              input logic [2:0] ack, input logic er,
                              input logic bz);
    vec_t v;
    v.pcinc = pi; v.pcload = pl; v.data = d; v.en = de;
    v.busy = bz; v.irq_ack = ack[2]; v.br_ack = ack[1];
    v.inc_ack = ack[0]; v.err = er;
    return v;
  endfunction

  function automatic logic [23:0] san(input logic [23:0] a);
    return a & 24'h7FFFFE;
  endfunction

  task automatic clear_reqs();
    rq.inc_req = 0; rq.br_req = 0; rq.irq_req = 0;
    rq.br_addr = '0; rq.irq_vec = '0;
    rq2.inc_req = 0; rq2.br_req = 0; rq2.irq_req = 0;
    rq2.br_addr = '0; rq2.irq_vec = '0;
  endtask

  task automatic test_reset();
    vec_t o;
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    o = obs(); checks++;
    if (o !== '0) begin
      errors++; $display("FAIL reset_hold got %h want 0", o);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = obs(); checks++;
      if (o !== '0) begin
        errors++; $display("FAIL reset_idle got %h want 0", o);
      end
    end
  endtask

  task automatic test_inc();
    vec_t o, e;
    @(negedge clk); rq.inc_req = 1;
    @(negedge clk); o = obs(); checks++;
    e = mk(1, 0, 16'h0, 0, 3'b000, 0, 1);
    if (o !== e) begin
      errors++; $display("FAIL inc_cmd got %h want %h", o, e);
    end
    @(negedge clk); o = obs(); checks++;
    e = mk(0, 0, 16'h0, 0, 3'b001, 0, 1);
    if (o !== e) begin
      errors++; $display("FAIL inc_ack got %h want %h", o, e);
    end
    rq.inc_req = 0;
    @(negedge clk); o = obs(); checks++;
    if (o !== '0 || pc_m !== 24'h000002) begin
      errors++;
      $display("FAIL inc_pc got %h pc %h want 0 pc 000002", o, pc_m);
    end
  endtask

  task automatic test_branch();
    vec_t o, e;
    @(negedge clk); rq.br_req = 1; rq.br_addr = 24'h012346;
    @(negedge clk); o = obs(); checks++;
    e = mk(0, 1, 16'h0, 0, 3'b000, 0, 1);
    if (o !== e) begin
      errors++; $display("FAIL br_cmd got %h want %h", o, e);
    end
    rq.br_req = 0; rq.br_addr = 24'hABCDEF;
    @(negedge clk); o = obs(); checks++;
    e = mk(0, 0, 16'h2346, 1, 3'b000, 0, 1);
    if (o !== e) begin
      errors++; $display("FAIL br_lsw got %h want %h", o, e);
    end
    @(negedge clk); o = obs(); checks++;
    e = mk(0, 0, 16'h0001, 1, 3'b010, 0, 1);
    if (o !== e) begin
      errors++; $display("FAIL br_msw got %h want %h", o, e);
    end
    @(negedge clk); o = obs(); checks++;
    if (o !== '0 || pc_m !== 24'h012346) begin
      errors++;
      $display("FAIL br_pc got %h pc %h want 0 pc 012346", o, pc_m);
    end
  endtask

  task automatic test_priority();
    vec_t o;
    int order[$];
    logic [15:0] lsw;
    lsw = '0;
    @(negedge clk);
    rq.irq_req = 1; rq.irq_vec = 8'h05;
    rq.br_req = 1; rq.br_addr = 24'h000200;
    rq.inc_req = 1;
    for (int c = 0; c < 24 && order.size() < 3; c++) begin
      @(negedge clk);
      o = obs();
      if (o.en && !(o.irq_ack | o.br_ack)) lsw = o.data;
      if (o.irq_ack) begin
        order.push_back(2); rq.irq_req = 0; checks++;
        if (lsw !== 16'h000E || o.data !== 16'h0) begin
          errors++;
          $display("FAIL prio_irq_addr got %h_%h want 0000_000e",
                   o.data, lsw);
        end
      end
      if (o.br_ack) begin
        order.push_back(1); rq.br_req = 0; checks++;
        if (lsw !== 16'h0200) begin
          errors++;
          $display("FAIL prio_br_addr got %h want 0200", lsw);
        end
      end
      if (o.inc_ack) begin
        order.push_back(0); rq.inc_req = 0;
      end
    end
    checks++;
    if (order.size() != 3 || order[0] != 2 || order[1] != 1
        || order[2] != 0) begin
      errors++;
      $display("FAIL prio_order got %p want 2 1 0", order);
    end
    @(negedge clk);
  endtask

  task automatic test_sanitise();
    vec_t o, e;
    @(negedge clk); rq.br_req = 1; rq.br_addr = 24'h800003;
    rq2.irq_req = 1; rq2.irq_vec = 8'h01;
    @(negedge clk);
    rq.br_req = 0; rq2.irq_req = 0;
    @(negedge clk); o = obs(); checks++;
    e = mk(0, 0, 16'h0002, 1, 3'b000, 0, 1);
    if (o !== e) begin
      errors++; $display("FAIL san_lsw got %h want %h", o, e);
    end
    o = obs2(); checks++;
    e = mk(0, 0, 16'h0000, 1, 3'b000, 0, 1);
    if (o !== e) begin
      errors++; $display("FAIL wrap_lsw got %h want %h", o, e);
    end
    @(negedge clk); o = obs(); checks++;
    e = mk(0, 0, 16'h0000, 1, 3'b010, 1, 1);
    if (o !== e) begin
      errors++; $display("FAIL san_msw got %h want %h", o, e);
    end
    o = obs2(); checks++;
    e = mk(0, 0, 16'h0000, 1, 3'b100, 0, 1);
    if (o !== e) begin
      errors++; $display("FAIL wrap_msw got %h want %h", o, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    vec_t o;
    logic prev_inc;
    logic want;
    prev_inc = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c > 0) begin
        o = obs();
        want = ((c - 1) % 3 == 0) && (c <= 10);
        checks++;
        if (o.pcinc !== want || o.pcload !== 1'b0
            || (prev_inc && o.pcinc)) begin
          errors++;
          $display("FAIL b2b_c%0d got inc %b load %b want inc %b",
                   c, o.pcinc, o.pcload, want);
        end
        prev_inc = o.pcinc;
      end
      rq.inc_req = (c < 10);
    end
  endtask

  task automatic test_reset_mid();
    vec_t o;
    @(negedge clk); rq.br_req = 1; rq.br_addr = 24'h004444;
    @(negedge clk);
    @(negedge clk); o = obs(); checks++;
    if (o.en !== 1'b1 || o.data !== 16'h4444) begin
      errors++;
      $display("FAIL rstmid_lsw got %h want data 4444", o);
    end
    rst_n = 1'b0; rq.br_req = 0;
    @(negedge clk); o = obs(); checks++;
    if (o !== '0) begin
      errors++; $display("FAIL rstmid_out got %h want 0", o);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); o = obs(); checks++;
      if (o !== '0) begin
        errors++; $display("FAIL rstmid_noack got %h want 0", o);
      end
    end
  endtask

  task automatic test_random();
    vec_t exp_q[$];
    vec_t e, o;
    logic [2:0] acc;
    logic [23:0] pc_exp, ld_exp, raw;
    bit pc_chk, idle;
    int n_acks;
    rst_n = 1'b0; clear_reqs();
    @(negedge clk); rst_n = 1'b1;
    acc = '0; pc_exp = '0; ld_exp = '0; pc_chk = 0; n_acks = 0;
    for (int c = 0; c < 640; c++) begin
      @(negedge clk);
      idle = (exp_q.size() == 0);
      e = idle ? vec_t'('0) : exp_q.pop_front();
      o = obs(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL rand_c%0d got %h want %h", c, o, e);
      end
      if (pc_chk) begin
        checks++; pc_chk = 0;
        if (pc_m !== pc_exp) begin
          errors++;
          $display("FAIL rand_pc_c%0d got %h want %h", c, pc_m, pc_exp);
        end
      end
      if (e.inc_ack) begin
        acc[0] = 0; n_acks++; pc_chk = 1;
        pc_exp = (pc_exp + 24'd2) & 24'h7FFFFF;
        if (c >= 580 || $urandom_range(1) == 0) rq.inc_req = 0;
      end
      if (e.br_ack | e.irq_ack) begin
        n_acks++; pc_chk = 1; pc_exp = ld_exp;
      end
      if (e.br_ack) begin
        acc[1] = 0;
        if (c >= 580 || $urandom_range(1) == 0) rq.br_req = 0;
      end
      if (e.irq_ack) begin
        acc[2] = 0;
        if (c >= 580 || $urandom_range(1) == 0) rq.irq_req = 0;
      end
      if (acc[1] && $urandom_range(3) == 0) begin
        rq.br_req = 0; rq.br_addr = 24'($urandom);
      end
      if (acc[2] && $urandom_range(3) == 0) begin
        rq.irq_req = 0; rq.irq_vec = 8'($urandom);
      end
      if (c < 580) begin
        if (!rq.inc_req && !acc[0] && $urandom_range(2) == 0)
          rq.inc_req = 1;
        if (!rq.br_req && !acc[1] && $urandom_range(4) == 0) begin
          rq.br_req = 1; rq.br_addr = 24'($urandom);
        end
        if (!rq.irq_req && !acc[2] && $urandom_range(6) == 0) begin
          rq.irq_req = 1; rq.irq_vec = 8'($urandom);
        end
      end
      if (idle && (rq.irq_req || rq.br_req)) begin
        if (rq.irq_req) begin
          raw = 24'(32'(IVT1) + 2 * int'(rq.irq_vec));
          acc[2] = 1;
        end else begin
          raw = rq.br_addr;
          acc[1] = 1;
        end
        ld_exp = san(raw);
        exp_q.push_back(mk(0, 1, 16'h0, 0, 3'b000, 0, 1));
        exp_q.push_back(mk(0, 0, ld_exp[15:0], 1, 3'b000, 0, 1));
        exp_q.push_back(mk(0, 0, {8'h00, ld_exp[23:16]}, 1,
                           {acc[2], acc[1], 1'b0},
                           raw[23] | raw[0], 1));
      end else if (idle && rq.inc_req) begin
        acc[0] = 1;
        exp_q.push_back(mk(1, 0, 16'h0, 0, 3'b000, 0, 1));
        exp_q.push_back(mk(0, 0, 16'h0, 0, 3'b001, 0, 1));
      end
    end
    checks++;
    if (exp_q.size() != 0 || obs() !== '0 || n_acks < 40) begin
      errors++;
      $display("FAIL rand_drain got pend %0d acks %0d out %h",
               exp_q.size(), n_acks, obs());
    end
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_inc();
    test_branch();
    test_priority();
    test_sanitise();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
